// File: rtl/mem_responder.sv
// mem_responder
//    Memory-side responder for the core's instruction-fetch and data ports.
//    Holds IMEM and DMEM, answers reads combinationally and commits data
//    writes on the clock edge. After Reset a byte-serial boot loader fills
//    IMEM from a big-endian stream (16-bit word count, then the words). The
//    core is held in reset until loading completes.
//
//    state | meaning
//    ------+----------------------------------------------------------
//    HDR0  | waiting for word-count high byte
//    HDR1  | waiting for word-count low byte
//    WORD  | receiving instruction words, four bytes each, MSB first
//    RUN   | load complete, core released, loader stream ignored
//
// Ports
//    Clock, Reset          rising-edge clock, synchronous active-high reset
//    InstrAddr / InstrMem  instruction word address / word (0 unless RUN)
//    MemAddr, MemRead,     data word address, read/write strobes and store
//    MemWrite, WriteData   data (accesses are honoured only in RUN)
//    MemData               load data (0 unless MemRead in RUN)
//    LoadValid, LoadByte,  loader byte handshake; byte accepted when
//    LoadReady             LoadValid && LoadReady
//    LoadDone, CpunReset   high only in RUN
module mem_responder #(
   parameter int IAW = 8,
   parameter int DAW = 8
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] InstrAddr,
   output logic [31:0] InstrMem,
   input  logic [15:0] MemAddr,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] WriteData,
   output logic [31:0] MemData,
   input  logic        LoadValid,
   input  logic [7:0]  LoadByte,
   output logic        LoadReady,
   output logic        LoadDone,
   output logic        CpunReset
);

   typedef enum logic [1:0] {HDR0, HDR1, WORD, RUN} loadState_t;

   loadState_t  state;
   logic [15:0] count;
   logic [15:0] wordIdx;
   logic [1:0]  byteIdx;
   logic [23:0] byteBuf;

   logic [31:0] imem [2**IAW];
   logic [31:0] dmem [2**DAW];

   logic           accept;
   logic           imemWe;
   logic           dmemWe;
   logic [IAW-1:0] instrIdx;
   logic [DAW-1:0] dataIdx;
   logic           unusedAddrBits;

   // Upper address bits are intentionally dropped so accesses alias.
   assign instrIdx       = InstrAddr[IAW-1:0];
   assign dataIdx        = MemAddr[DAW-1:0];
   assign unusedAddrBits = ^{InstrAddr[15:IAW], MemAddr[15:DAW]};

   assign LoadReady = (state != RUN);
   assign LoadDone  = (state == RUN);
   assign CpunReset = (state == RUN);

   assign accept = LoadValid && LoadReady;
   assign imemWe = !Reset && accept && (state == WORD) && (byteIdx == 2'd3);
   assign dmemWe = !Reset && MemWrite && (state == RUN);

   assign InstrMem = (state == RUN) ? imem[instrIdx] : 32'h0;
   assign MemData  = (MemRead && state == RUN) ? dmem[dataIdx] : 32'h0;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= HDR0;
         count   <= 16'h0;
         wordIdx <= 16'h0;
         byteIdx <= 2'd0;
         byteBuf <= 24'h0;
      end else if (accept) begin
         case (state)
            HDR0: begin
               count[15:8] <= LoadByte;
               state       <= HDR1;
            end
            HDR1: begin
               count[7:0] <= LoadByte;
               if ({count[15:8], LoadByte} == 16'h0) begin
                  state <= RUN;
               end else begin
                  wordIdx <= 16'h0;
                  byteIdx <= 2'd0;
                  state   <= WORD;
               end
            end
            WORD: begin
               byteBuf <= {byteBuf[15:0], LoadByte};
               byteIdx <= byteIdx + 2'd1;
               if (byteIdx == 2'd3) begin
                  wordIdx <= wordIdx + 16'd1;
                  if ((wordIdx + 16'd1) == count) begin
                     state <= RUN;
                  end
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   // The fourth byte completes the word straight from the input so it lands
   // on the same edge it is accepted.
   always_ff @(posedge Clock) begin
      if (imemWe) begin
         imem[wordIdx[IAW-1:0]] <= {byteBuf, LoadByte};
      end
   end

   always_ff @(posedge Clock) begin
      if (dmemWe) begin
         dmem[dataIdx] <= WriteData;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   logic        Clock;
   logic        Reset;
   logic [15:0] InstrAddr;
   logic [31:0] InstrMem;
   logic [15:0] MemAddr;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] WriteData;
   logic [31:0] MemData;
   logic        LoadValid;
   logic [7:0]  LoadByte;
   logic        LoadReady;
   logic        LoadDone;
   logic        CpunReset;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acceptedBytes = 0;

   mem_responder #(.IAW(8), .DAW(8)) dut (
      .Clock(Clock), .Reset(Reset),
      .InstrAddr(InstrAddr), .InstrMem(InstrMem),
      .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite),
      .WriteData(WriteData), .MemData(MemData),
      .LoadValid(LoadValid), .LoadByte(LoadByte), .LoadReady(LoadReady),
      .LoadDone(LoadDone), .CpunReset(CpunReset)
   );

   initial begin
      Clock = 0;
      forever #5 Clock = ~Clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The loader is modelled as a byte stream: byte n of the stream is either a
   // header byte or byte (n-2)%4 of word (n-2)/4; the load finishes once
   // 2 + 4*count bytes have been taken.
   bit          modelKnown = 0;
   bit          running = 0;
   int          nBytes = 0;
   int          cnt = 0;
   logic [31:0] wbuf = 0;
   logic [31:0] mImem [256];
   bit          mIValid [256];
   logic [31:0] mDmem [256];
   bit          mDValid [256];

   always @(posedge Clock) begin
      cyc++;
      if (!Reset && LoadValid && LoadReady) acceptedBytes++;
      if (Reset) begin
         modelKnown = 1;
         running = 0;
         nBytes = 0;
      end else if (modelKnown) begin
         if (!running && LoadValid) begin
            if (nBytes == 0) cnt = int'(LoadByte) * 256;
            else if (nBytes == 1) cnt = cnt + int'(LoadByte);
            else begin
               wbuf = {wbuf[23:0], LoadByte};
               if ((nBytes - 2) % 4 == 3) begin
                  mImem[((nBytes - 2) / 4) % 256] = wbuf;
                  mIValid[((nBytes - 2) / 4) % 256] = 1;
               end
            end
            nBytes++;
            if (nBytes >= 2 && nBytes == 2 + 4 * cnt) running = 1;
         end else if (running && MemWrite) begin
            mDmem[int'(MemAddr) % 256] = WriteData;
            mDValid[int'(MemAddr) % 256] = 1;
         end
      end
   end

   always @(negedge Clock) begin
      if (modelKnown) begin
         check("LoadReady", {31'h0, LoadReady}, {31'h0, !running});
         check("LoadDone", {31'h0, LoadDone}, {31'h0, running});
         check("CpunReset", {31'h0, CpunReset}, {31'h0, running});
         if (!running) check("InstrMemIdle", InstrMem, 32'h0);
         else if (mIValid[int'(InstrAddr) % 256]) check("InstrMem", InstrMem, mImem[int'(InstrAddr) % 256]);
         if (!(running && MemRead)) check("MemDataIdle", MemData, 32'h0);
         else if (mDValid[int'(MemAddr) % 256]) check("MemData", MemData, mDmem[int'(MemAddr) % 256]);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic doReset();
      Reset = 1;
      LoadValid = 0;
      MemWrite = 0;
      MemRead = 0;
      @(posedge Clock); #1;
      Reset = 0;
   endtask

   task automatic sendByte(input logic [7:0] b);
      int tries = 0;
      LoadValid = 1;
      LoadByte = b;
      while (!LoadReady && tries < 20) begin
         @(posedge Clock); #1;
         tries++;
      end
      if (tries >= 20) begin
         errors++;
         checks++;
         $display("FAIL sendByte timeout: LoadReady stayed %b required 1", LoadReady);
      end
      @(posedge Clock); #1;
   endtask

   task automatic loadWords(input logic [31:0] w0, input logic [31:0] w1, input int n);
      sendByte(8'(n >> 8));
      sendByte(8'(n));
      for (int i = 0; i < n; i++) begin
         logic [31:0] w;
         w = (i == 0) ? w0 : w1;
         for (int b = 0; b < 4; b++) sendByte(w[31 - 8 * b -: 8]);
      end
   endtask

   logic [7:0] seq [6] = '{8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};

   initial begin
      int c0, a0, k;
      logic acc;
      Reset = 1; InstrAddr = 0; MemAddr = 0; MemRead = 0; MemWrite = 0;
      WriteData = 0; LoadValid = 0; LoadByte = 0;
      repeat (2) @(posedge Clock);
      #1;
      check("rstLoadReady", {31'h0, LoadReady}, 32'h1);
      check("rstLoadDone", {31'h0, LoadDone}, 32'h0);
      check("rstCpunReset", {31'h0, CpunReset}, 32'h0);
      Reset = 0;

      // 1: two-word load with continuous valid
      c0 = cyc; a0 = acceptedBytes;
      loadWords(32'h20080005, 32'h00000000, 2);
      LoadValid = 0;
      check("t1Cycles", cyc - c0, 10);
      check("t1Accepted", acceptedBytes - a0, 10);
      check("t1CpunReset", {31'h0, CpunReset}, 32'h1);
      InstrAddr = 0; #1;
      check("t1Imem0", InstrMem, 32'h20080005);
      InstrAddr = 1; #1;
      check("t1Imem1", InstrMem, 32'h0);

      // 2: empty image
      doReset();
      c0 = cyc;
      sendByte(8'h00); sendByte(8'h00);
      LoadValid = 0;
      check("t2Cycles", cyc - c0, 2);
      check("t2LoadDone", {31'h0, LoadDone}, 32'h1);
      InstrAddr = 0; #1;
      check("t2Imem0", InstrMem, 32'h20080005);

      // 3: LoadValid toggling every cycle
      doReset();
      a0 = acceptedBytes; k = 0;
      for (int c = 0; c < 12; c++) begin
         LoadValid = (c % 2 == 0) && (k < 6);
         LoadByte = seq[(k < 6) ? k : 5];
         #1;
         acc = LoadValid && LoadReady;
         @(posedge Clock); #1;
         if (acc) k++;
      end
      LoadValid = 0;
      check("t3Accepted", acceptedBytes - a0, 6);
      InstrAddr = 0; #1;
      check("t3Imem0", InstrMem, 32'hA1B2C3D4);
      LoadValid = 1; LoadByte = 8'hFF;
      repeat (3) begin @(posedge Clock); #1; end
      check("t3ReadyRun", {31'h0, LoadReady}, 32'h0);
      check("t3ImemKept", InstrMem, 32'hA1B2C3D4);
      check("t3AcceptedKept", acceptedBytes - a0, 6);
      LoadValid = 0;

      // 4: data memory in RUN
      MemAddr = 5; WriteData = 32'h11111111; MemWrite = 1;
      @(posedge Clock); #1;
      MemAddr = 7; WriteData = 32'h77777777;
      @(posedge Clock); #1;
      MemAddr = 5; WriteData = 32'hDEADBEEF; MemRead = 1; #1;
      check("t4ReadDuringWrite", MemData, 32'h11111111);
      @(posedge Clock); #1;
      MemWrite = 0; #1;
      check("t4NewWord", MemData, 32'hDEADBEEF);
      MemAddr = 16'h0105; #1;
      check("t4Alias", MemData, 32'hDEADBEEF);
      MemRead = 0; #1;
      check("t4NoRead", MemData, 32'h0);

      // 5: reset in the middle of a load; stray data writes dropped
      doReset();
      MemWrite = 1; MemAddr = 7; WriteData = 32'hBAD0BAD0;
      sendByte(8'h00); sendByte(8'h02);
      sendByte(8'h55); sendByte(8'h66); sendByte(8'h77);
      LoadValid = 0; MemWrite = 0;
      Reset = 1;
      @(posedge Clock); #1;
      check("t5CpunReset", {31'h0, CpunReset}, 32'h0);
      check("t5LoadReady", {31'h0, LoadReady}, 32'h1);
      Reset = 0;
      MemWrite = 1;
      loadWords(32'h11223344, 32'h0, 1);
      LoadValid = 0; MemWrite = 0;
      InstrAddr = 0; #1;
      check("t5Imem0", InstrMem, 32'h11223344);
      InstrAddr = 1; #1;
      check("t5Imem1", InstrMem, 32'h0);
      MemAddr = 7; MemRead = 1; #1;
      check("t5StrayDropped", MemData, 32'h77777777);
      MemRead = 0;

      // 6: count = 2^IAW + 1 wraps the index
      doReset();
      a0 = acceptedBytes;
      sendByte(8'h01); sendByte(8'h01);
      for (int i = 0; i < 257; i++) begin
         logic [31:0] w;
         w = 32'hC0DE0000 + i;
         for (int b = 0; b < 4; b++) begin
            if (i == 256 && b == 3) check("t6NotDoneEarly", {31'h0, LoadDone}, 32'h0);
            sendByte(w[31 - 8 * b -: 8]);
         end
      end
      LoadValid = 0;
      check("t6LoadDone", {31'h0, LoadDone}, 32'h1);
      check("t6Accepted", acceptedBytes - a0, 1030);
      InstrAddr = 0; #1;
      check("t6Imem0Wrap", InstrMem, 32'hC0DE0100);
      InstrAddr = 1; #1;
      check("t6Imem1", InstrMem, 32'hC0DE0001);
      InstrAddr = 255; #1;
      check("t6Imem255", InstrMem, 32'hC0DE00FF);
      InstrAddr = 16'h0100; #1;
      check("t6ImemAlias", InstrMem, 32'hC0DE0100);

      @(posedge Clock); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
